// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for a trailing checksum byte.
package imem_pkg;
  localparam int IMEM_WORD_BYTES = 4;
  localparam int IMEM_ADDR_W     = 64;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_CHECK, ST_FINISH} loader_state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_FINISH} loader_state_t;
`endif
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: byte index 0 lands in bits [31:24].
// The mask tracks filled lanes, so a tail word comes out as 1000/1100/1110.
module byte_packer import imem_pkg::*; (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           push_i,
  input  logic [1:0]                     idx_i,
  input  logic [7:0]                     data_i,
  output logic [8*IMEM_WORD_BYTES-1:0]   word_o,
  output logic [IMEM_WORD_BYTES-1:0]     mask_o
);
  logic [8*IMEM_WORD_BYTES-1:0] word_q, word_d;
  logic [IMEM_WORD_BYTES-1:0]   mask_q, mask_d;
  logic [1:0]                   lane;

  // lane = 3 - idx; a cleared word keeps unused lanes at zero
  assign lane = ~idx_i;

  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    if (clr_i) begin
      word_d = '0;
      mask_d = '0;
    end else if (push_i) begin
      word_d[8*lane +: 8] = data_i;
      mask_d[lane]        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      mask_q <= '0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
    end
  end

  assign word_o = word_q;
  assign mask_o = mask_q;
endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as big-endian word writes, holding
// the core in reset meanwhile. IMEM_LOADER_CHECKSUM_EN enables a trailing checksum byte.
module imem_loader import imem_pkg::*; #(
  parameter int unsigned             MEM_SIZE  = 4095,
  parameter logic [IMEM_ADDR_W-1:0]  BASE_ADDR = 64'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            byte_count,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [IMEM_ADDR_W-1:0] wr_addr,
  output logic [31:0]            wr_data,
  output logic [3:0]             wr_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   core_hold
);
  loader_state_t          state_q;
  logic [15:0]            cnt_q, total_q;
  logic [IMEM_ADDR_W-1:0] addr_q;
  logic                   in_ready_q, wr_en_q, busy_q, done_q, err_q;
  logic                   push, clr, last_byte;
  logic [31:0]            pk_word;
  logic [3:0]             pk_mask;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             sum_q, ck_sum;
  assign ck_sum = sum_q + in_data;
`endif

  assign push      = in_ready_q & in_valid & (state_q == ST_LOAD);
  assign clr       = (state_q == ST_WRITE) | ((state_q == ST_IDLE) & start);
  assign last_byte = (cnt_q + 16'd1 == total_q);

  byte_packer u_packer (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (clr),
    .push_i (push),
    .idx_i  (cnt_q[1:0]),
    .data_i (in_data),
    .word_o (pk_word),
    .mask_o (pk_mask)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      total_q    <= '0;
      addr_q     <= BASE_ADDR;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          total_q <= byte_count;
          addr_q  <= BASE_ADDR;
          err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q   <= '0;
`endif
          if ({16'd0, byte_count} > MEM_SIZE) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else if (byte_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= ST_CHECK;
`else
            done_q     <= 1'b1;
            state_q    <= ST_FINISH;
`endif
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: if (in_valid) begin
          cnt_q <= cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q <= ck_sum;
`endif
          if (cnt_q[1:0] == 2'd3 || last_byte) begin
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          addr_q <= addr_q + IMEM_ADDR_W'(IMEM_WORD_BYTES);
          if (cnt_q == total_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= ST_CHECK;
`else
            done_q     <= 1'b1;
            state_q    <= ST_FINISH;
`endif
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: if (in_valid) begin
          if (ck_sum != 8'd0) err_q <= 1'b1;
          in_ready_q <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= ST_FINISH;
        end
`endif
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-port buses stay quiet outside the write strobe
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_en_q ? addr_q  : '0;
  assign wr_data   = wr_en_q ? pk_word : '0;
  assign wr_mask   = wr_en_q ? pk_mask : '0;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign core_hold = busy_q;
  assign done      = done_q;
  assign error     = err_q;
endmodule
